// File: rtl/conv_mac_pipe_pkg.sv
// rtl/conv_mac_pipe_pkg.sv - shared helpers for the KxK convolution MAC pipeline
package conv_mac_pipe_pkg;

  // ceil(log2(n)); 0 for n <= 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // width of an index counter; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // PROD_W: full signed product width
  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

  // SUM_W: sum of K*K products without overflow
  function automatic int sum_w(input int data_w, input int k);
    return prod_w(data_w) + clog2(k * k);
  endfunction

  // LSB position of tap 'tap' in a vector packed with tap 0 at the MSB
  function automatic int tap_base(input int tap, input int k, input int data_w);
    return (k * k - 1 - tap) * data_w;
  endfunction

  // clamp v into the signed range of an out_w-bit value
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // true when sat_clip would change v
  function automatic logic is_clipped(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/conv_mac_pipe_if.sv
// rtl/conv_mac_pipe_if.sv - window-beat input and result output handshake bundle
interface conv_mac_pipe_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int CIN    = 4,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16
);
  import conv_mac_pipe_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [K*K*DATA_W-1:0]         in_window;
  logic [K*K*DATA_W-1:0]         in_kernel;
  logic signed [ACC_W-1:0]       in_bias;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OUT_W-1:0]       out_data;
  logic                          out_sat;
  logic [idx_w(CIN)-1:0]         beat_idx;

  modport master (
    output in_valid, in_window, in_kernel, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat, beat_idx
  );

  modport slave (
    input  in_valid, in_window, in_kernel, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_sat, beat_idx
  );

endinterface

// File: rtl/conv_mac_pipe_postproc.sv
// rtl/conv_mac_pipe_postproc.sv - bias add, shift, optional ReLU (CONV_RELU_EN), clip
module conv_postproc
  import conv_mac_pipe_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] bias,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);
  localparam int V_W = ACC_W + 1;

  logic signed [V_W-1:0] v;
  logic signed [63:0]    v64;

  // one extra bit keeps acc+bias from wrapping; the shift truncates toward -inf
  always_comb begin
    v   = (V_W'(acc) + V_W'(bias)) >>> SHIFT;
    v64 = 64'(v);
`ifdef CONV_RELU_EN
    if (v64[63]) v64 = '0;
`endif
    data = OUT_W'(sat_clip(v64, OUT_W));
    sat  = is_clipped(v64, OUT_W);
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// rtl/conv_mac_pipe.sv - pipelined KxK x CIN convolution MAC; CONV_RELU_EN enables ReLU
module conv_mac_pipe
  import conv_mac_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int CIN    = 4,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input logic            clk,
  input logic            rst,
  conv_mac_pipe_if.slave bus
);
  localparam int TAPS   = K * K;
  localparam int PROD_W = prod_w(DATA_W);
  localparam int SUM_W  = sum_w(DATA_W, K);
  localparam int BI_W   = idx_w(CIN);
  localparam int WIN_W  = TAPS * DATA_W;
  localparam logic [BI_W-1:0] LAST_IDX = BI_W'(CIN - 1);

  if (ACC_W < 2 * DATA_W + clog2(TAPS * CIN) + 1) begin : g_acc_w_check
    $error("conv_mac_pipe: ACC_W too narrow for DATA_W/K/CIN");
  end

  logic                    stall, fire, first_beat, last_beat;
  logic [BI_W-1:0]         beat_idx;

  logic                    s0_valid, s0_first, s0_last;
  logic [WIN_W-1:0]        s0_win, s0_ker;
  logic signed [ACC_W-1:0] s0_bias;

  logic                    s1_valid, s1_first, s1_last;
  logic signed [PROD_W-1:0] s1_prod [TAPS];
  logic signed [ACC_W-1:0] s1_bias;

  logic                    s2_valid, s2_first, s2_last;
  logic signed [SUM_W-1:0] s2_sum, sum_c;
  logic signed [ACC_W-1:0] s2_bias;

  logic                    s3_valid;
  logic signed [ACC_W-1:0] acc, s3_bias;

  logic                    out_valid, out_sat, pp_sat;
  logic signed [OUT_W-1:0] out_data, pp_data;

  assign stall      = out_valid && !bus.out_ready;
  assign fire       = bus.in_valid && !stall;
  assign first_beat = (beat_idx == '0);
  assign last_beat  = (beat_idx == LAST_IDX);

  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_sat   = out_sat;
  assign bus.beat_idx  = beat_idx;

  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    localparam int B = tap_base(t, K, DATA_W);
    // one signed multiplier per tap
    always_ff @(posedge clk)
      if (!stall)
        s1_prod[t] <= PROD_W'($signed(s0_win[B +: DATA_W])) * PROD_W'($signed(s0_ker[B +: DATA_W]));
  end

  // sign-extending sum of all tap products
  always_comb begin
    sum_c = '0;
    for (int t = 0; t < TAPS; t++) sum_c = sum_c + SUM_W'(s1_prod[t]);
  end

  conv_postproc #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_postproc (
    .acc  (acc),
    .bias (s3_bias),
    .data (pp_data),
    .sat  (pp_sat)
  );

  // stage advance, beat counting, accumulation and output register; all hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx  <= '0;
      s0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      if (fire) beat_idx <= last_beat ? '0 : beat_idx + BI_W'(1);
      s0_valid <= fire;
      s0_first <= first_beat;
      s0_last  <= last_beat;
      s0_win   <= bus.in_window;
      s0_ker   <= bus.in_kernel;
      if (fire && last_beat) s0_bias <= bus.in_bias;

      s1_valid <= s0_valid;
      s1_first <= s0_first;
      s1_last  <= s0_last;
      s1_bias  <= s0_bias;

      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_sum   <= sum_c;
      s2_bias  <= s1_bias;

      // first beat of a pixel overwrites whatever the previous pixel left behind
      if (s2_valid) acc <= s2_first ? ACC_W'(s2_sum) : acc + ACC_W'(s2_sum);
      s3_valid <= s2_valid && s2_last;
      s3_bias  <= s2_bias;

      out_valid <= s3_valid;
      if (s3_valid) begin
        out_data <= pp_data;
        out_sat  <= pp_sat;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb/tb_conv_mac_pipe.sv - scoreboard bench for conv_mac_pipe (three configurations)
module tb_conv_mac_pipe;
  import conv_mac_pipe_pkg::*;

`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    logic signed [15:0] data;
    logic               sat;
    string              tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_acc = 0;
  exp_t q1[$], q2[$], q3[$];
  int   arr1[$], arr3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_mac_pipe_if #(.DATA_W(8), .K(3), .CIN(4), .ACC_W(24), .OUT_W(16)) bus1 ();
  conv_mac_pipe_if #(.DATA_W(8), .K(3), .CIN(4), .ACC_W(24), .OUT_W(16)) bus2 ();
  conv_mac_pipe_if #(.DATA_W(8), .K(3), .CIN(1), .ACC_W(24), .OUT_W(16)) bus3 ();

  conv_mac_pipe #(.DATA_W(8), .K(3), .CIN(4), .ACC_W(24), .OUT_W(16), .SHIFT(0))
    dut (.clk(clk), .rst(rst), .bus(bus1.slave));
  conv_mac_pipe #(.DATA_W(8), .K(3), .CIN(4), .ACC_W(24), .OUT_W(16), .SHIFT(2))
    dut_shift (.clk(clk), .rst(rst), .bus(bus2.slave));
  conv_mac_pipe #(.DATA_W(8), .K(3), .CIN(1), .ACC_W(24), .OUT_W(16), .SHIFT(0))
    dut_cin1 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [71:0] rep(input logic [7:0] v);
    return {9{v}};
  endfunction

  task automatic expect1(input int d, input bit s, input string tag);
    exp_t e;
    e.data = 16'(d); e.sat = s; e.tag = tag;
    q1.push_back(e);
  endtask

  task automatic expect2(input int d, input bit s, input string tag);
    exp_t e;
    e.data = 16'(d); e.sat = s; e.tag = tag;
    q2.push_back(e);
  endtask

  task automatic expect3(input int d, input bit s, input string tag);
    exp_t e;
    e.data = 16'(d); e.sat = s; e.tag = tag;
    q3.push_back(e);
  endtask

  // monitors: pop and compare on every output handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      arr1.push_back(cyc);
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_unexpected: got %0d expected no output", bus1.out_data);
      end else begin
        e = q1.pop_front();
        check({e.tag, "_data"}, bus1.out_data, e.data);
        check({e.tag, "_sat"}, bus1.out_sat, e.sat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus2.out_valid && bus2.out_ready) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL shift_unexpected: got %0d expected no output", bus2.out_data);
      end else begin
        e = q2.pop_front();
        check({e.tag, "_data"}, bus2.out_data, e.data);
        check({e.tag, "_sat"}, bus2.out_sat, e.sat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus3.out_valid && bus3.out_ready) begin
      arr3.push_back(cyc);
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL cin1_unexpected: got %0d expected no output", bus3.out_data);
      end else begin
        e = q3.pop_front();
        check({e.tag, "_data"}, bus3.out_data, e.data);
        check({e.tag, "_sat"}, bus3.out_sat, e.sat);
      end
    end
  end

  // one beat into the main instance; called and returns on a falling edge
  task automatic beat(input logic [7:0] p, input logic [7:0] w, input logic signed [23:0] b);
    int g = 0;
    bus1.in_window = rep(p);
    bus1.in_kernel = rep(w);
    bus1.in_bias   = b;
    bus1.in_valid  = 1'b1;
    while (!bus1.in_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    last_acc = cyc;
    bus1.in_valid = 1'b0;
  endtask

  // four beats; non-last beats carry a junk bias that must be ignored
  task automatic pixel(input logic [7:0] p, input logic [7:0] w, input logic signed [23:0] b);
    for (int i = 0; i < 4; i++) beat(p, w, (i == 3) ? b : 24'sd777);
  endtask

  task automatic pixel2(input logic [7:0] p, input logic [7:0] w, input logic signed [23:0] b);
    for (int i = 0; i < 4; i++) begin
      bus2.in_window = rep(p);
      bus2.in_kernel = rep(w);
      bus2.in_bias   = (i == 3) ? b : 24'sd555;
      bus2.in_valid  = 1'b1;
      @(negedge clk);
    end
    bus2.in_valid = 1'b0;
  endtask

  task automatic beat3(input logic [7:0] p, input logic [7:0] w, input logic signed [23:0] b);
    bus3.in_window = rep(p);
    bus3.in_kernel = rep(w);
    bus3.in_bias   = b;
    bus3.in_valid  = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    while ((q1.size() + q2.size() + q3.size()) != 0 && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", q1.size() + q2.size() + q3.size());
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    bus1.in_valid = 0; bus1.in_window = '0; bus1.in_kernel = '0; bus1.in_bias = '0; bus1.out_ready = 1;
    bus2.in_valid = 0; bus2.in_window = '0; bus2.in_kernel = '0; bus2.in_bias = '0; bus2.out_ready = 1;
    bus3.in_valid = 0; bus3.in_window = '0; bus3.in_kernel = '0; bus3.in_bias = '0; bus3.out_ready = 1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus1.out_valid, 0);
    check("rst_out_data", bus1.out_data, 0);
    check("rst_out_sat", bus1.out_sat, 0);
    check("rst_beat_idx", bus1.beat_idx, 0);
    check("rst_in_ready", bus1.in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // all ones: 9 taps x 4 beats = 36, four cycles after the last beat
    arr1.delete();
    expect1(36, 0, "ones");
    pixel(8'sd1, 8'sd1, 0);
    begin
      int t_last;
      t_last = last_acc;
      drain();
      check("ones_latency", (arr1.size() > 0) ? arr1[0] - t_last : -1, 4);
    end

    // saturation, sign, ReLU and clip boundaries
    expect1(32767, 1, "pos_clip");
    pixel(-8'sd128, -8'sd128, 0);
    expect1(RELU ? 0 : -32768, RELU ? 0 : 1, "neg_clip");
    pixel(-8'sd128, 8'sd127, 0);
    expect1(RELU ? 0 : -116, 0, "mixed");
    pixel(8'sd2, -8'sd3, 100);
    expect1(32767, 0, "hi_edge");
    pixel(8'sd1, 8'sd1, 32731);
    expect1(32767, 1, "hi_over");
    pixel(8'sd1, 8'sd1, 32732);
    expect1(RELU ? 0 : -32768, 0, "lo_edge");
    pixel(8'sd1, 8'sd1, -32804);
    expect1(RELU ? 0 : -32768, RELU ? 0 : 1, "lo_over");
    pixel(8'sd1, 8'sd1, -32805);
    drain();

    // backpressure: first result held five cycles, then all three in order
    @(posedge clk); #1 bus1.out_ready = 1'b0;
    @(negedge clk);
    expect1(37, 0, "bp0");
    expect1(38, 0, "bp1");
    expect1(39, 0, "bp2");
    fork
      begin
        pixel(8'sd1, 8'sd1, 1);
        pixel(8'sd1, 8'sd1, 2);
        pixel(8'sd1, 8'sd1, 3);
      end
      begin
        g = 0;
        while (!bus1.out_valid && g < 100) begin @(negedge clk); g++; end
        for (int i = 0; i < 5; i++) begin
          check("bp_in_ready", bus1.in_ready, 0);
          check("bp_out_valid", bus1.out_valid, 1);
          check("bp_out_data", bus1.out_data, 37);
          @(negedge clk);
        end
        @(posedge clk); #1 bus1.out_ready = 1'b1;
      end
    join
    drain();

    // reset mid-pixel discards the partial sum; paused pixel afterwards
    beat(8'sd1, 8'sd1, 777);
    beat(8'sd1, 8'sd1, 777);
    check("mid_beat_idx", bus1.beat_idx, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_beat_idx", bus1.beat_idx, 0);
    check("rst2_out_valid", bus1.out_valid, 0);
    rst = 1'b0;
    expect1(36, 0, "after_rst");
    beat(8'sd1, 8'sd1, 777);
    beat(8'sd1, 8'sd1, 777);
    repeat (3) @(negedge clk);
    beat(8'sd1, 8'sd1, 777);
    beat(8'sd1, 8'sd1, 0);
    drain();

    // back-to-back pixels, distinct biases, 4-cycle spacing
    arr1.delete();
    expect1(36, 0, "b2b0");
    expect1(46, 0, "b2b1");
    expect1(31, 0, "b2b2");
    pixel(8'sd1, 8'sd1, 0);
    pixel(8'sd1, 8'sd1, 10);
    pixel(8'sd1, 8'sd1, -5);
    drain();
    check("b2b_gap0", (arr1.size() == 3) ? arr1[1] - arr1[0] : -1, 4);
    check("b2b_gap1", (arr1.size() == 3) ? arr1[2] - arr1[1] : -1, 4);

    // SHIFT=2 instance
    expect2(50, 0, "shift_pos");
    expect2(RELU ? 0 : -10, 0, "shift_neg");
    expect2(32767, 1, "shift_clip");
    pixel2(8'sd2, 8'sd3, -16);
    pixel2(8'sd1, -8'sd1, -1);
    pixel2(8'sd127, 8'sd127, 0);
    drain();

    // CIN=1 instance: one result per beat, one cycle apart
    arr3.delete();
    expect3(9, 0, "cin1_a");
    expect3(59, 0, "cin1_b");
    expect3(RELU ? 0 : -9, 0, "cin1_c");
    beat3(8'sd1, 8'sd1, 0);
    beat3(8'sd2, 8'sd3, 5);
    beat3(-8'sd1, 8'sd1, 0);
    bus3.in_valid = 1'b0;
    check("cin1_beat_idx", bus3.beat_idx, 0);
    drain();
    check("cin1_gap0", (arr3.size() == 3) ? arr3[1] - arr3[0] : -1, 1);
    check("cin1_gap1", (arr3.size() == 3) ? arr3[2] - arr3[1] : -1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
